btn_press_classifier: RTL and testbench

//  Consumes the debounced, clk-synchronous button level from the debounce stage.

---
 rtl/btn_press_classifier.sv | 98 +++++++++
 tb/tb_btn_press_classifier.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/btn_press_classifier.sv
// Turns a debounced, clk-synchronous button level into short, long and auto-repeat
// command pulses. All outputs are registered, and one instance serves one button.
module btn_press_classifier #(
   parameter int ACTIVE_LOW    = 1,
   parameter int LONG_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 5_000_000,
   parameter int CNT_W         = 25
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_lvl,
   output logic pressed,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

   localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_MAX  = (REPEAT_CYCLES == 0) ? '0 : CNT_W'(REPEAT_CYCLES - 1);
   localparam bit               REP_EN   = (REPEAT_CYCLES != 0);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             act, act_q;
   logic             short_nxt, long_nxt, repeat_nxt;

   assign act = (ACTIVE_LOW != 0) ? ~btn_lvl : btn_lvl;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      short_nxt  = 1'b0;
      long_nxt   = 1'b0;
      repeat_nxt = 1'b0;
      case (state)
         IDLE: begin
            // A press only counts on a fresh rising edge of act.
            if (act && !act_q) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
            end
         end
         PRESSED: begin
            // Release is tested first, so it wins over a simultaneous threshold.
            if (!act) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               short_nxt = 1'b1;
            end else if (cnt == LONG_MAX) begin
               state_nxt = HELD;
               cnt_nxt   = '0;
               long_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (!act) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (REP_EN && (cnt == REP_MAX)) begin
               repeat_nxt = 1'b1;
               cnt_nxt    = '0;
            end else if (REP_EN) begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // act_q comes out of reset as 1, so a button held through reset is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         act_q        <= 1'b1;
         pressed      <= 1'b0;
         short_pulse  <= 1'b0;
         long_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         act_q        <= act;
         pressed      <= act;
         short_pulse  <= short_nxt;
         long_pulse   <= long_nxt;
         repeat_pulse <= repeat_nxt;
      end
   end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Randomized and directed stimulus for three classifier configurations, checked
// against a duration-based reference model of press classification.
module tb_btn_press_classifier;

   localparam int L = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] btn;
   logic [2:0] pr, sh, lg, rp;

   // inst 0: R=4 active-low, inst 1: R=0 active-low, inst 2: R=4 active-high
   localparam logic [2:0] AL_MASK = 3'b011;
   int rep_cyc [3] = '{4, 0, 4};

   int checks   = 0;
   int failures = 0;

   bit prev_act [3];
   bit in_press [3];
   int dur      [3];
   bit e_pr [3], e_sh [3], e_lg [3], e_rp [3];
   int model_cmd_cnt = 0;
   int dut_cmd_cnt   = 0;

   always #5 clk = ~clk;

   btn_press_classifier #(.ACTIVE_LOW(1), .LONG_CYCLES(L), .REPEAT_CYCLES(4), .CNT_W(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .btn_lvl(btn[0]),
      .pressed(pr[0]), .short_pulse(sh[0]), .long_pulse(lg[0]), .repeat_pulse(rp[0]));

   btn_press_classifier #(.ACTIVE_LOW(1), .LONG_CYCLES(L), .REPEAT_CYCLES(0), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .btn_lvl(btn[1]),
      .pressed(pr[1]), .short_pulse(sh[1]), .long_pulse(lg[1]), .repeat_pulse(rp[1]));

   btn_press_classifier #(.ACTIVE_LOW(0), .LONG_CYCLES(L), .REPEAT_CYCLES(4), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .btn_lvl(btn[2]),
      .pressed(pr[2]), .short_pulse(sh[2]), .long_pulse(lg[2]), .repeat_pulse(rp[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int unsigned i = 0; i < 3; i++) begin
         prev_act[i] = 1'b1;
         in_press[i] = 1'b0;
         dur[i]      = 0;
         e_pr[i] = 1'b0; e_sh[i] = 1'b0; e_lg[i] = 1'b0; e_rp[i] = 1'b0;
      end
   endtask

   // dur = clock edges elapsed since the qualifying press edge
   task automatic model_step(input int unsigned i, input bit act);
      int dn;
      e_sh[i] = 1'b0; e_lg[i] = 1'b0; e_rp[i] = 1'b0;
      if (in_press[i]) begin
         dn = dur[i] + 1;
         if (!act) begin
            in_press[i] = 1'b0;
            e_sh[i] = (dn <= L);
         end else begin
            dur[i]  = dn;
            e_lg[i] = (dn == L);
            e_rp[i] = (rep_cyc[i] != 0) && (dn > L) && (((dn - L) % rep_cyc[i]) == 0);
         end
      end else if (act && !prev_act[i]) begin
         in_press[i] = 1'b1;
         dur[i]      = 0;
      end
      prev_act[i] = act;
      e_pr[i]     = act;
      if (i == 0 && (e_sh[i] || e_lg[i])) model_cmd_cnt++;
   endtask

   task automatic check_outputs(input string ph);
      for (int unsigned i = 0; i < 3; i++) begin
         check($sformatf("%s_pressed%0d", ph, i), 32'(pr[i]), 32'(e_pr[i]));
         check($sformatf("%s_short%0d", ph, i),   32'(sh[i]), 32'(e_sh[i]));
         check($sformatf("%s_long%0d", ph, i),    32'(lg[i]), 32'(e_lg[i]));
         check($sformatf("%s_repeat%0d", ph, i),  32'(rp[i]), 32'(e_rp[i]));
      end
      if (sh[0] || lg[0]) dut_cmd_cnt++;
   endtask

   // a[i] is the logical "button down" level of instance i
   task automatic cycle(input logic [2:0] a, input string ph);
      btn = a ^ AL_MASK;
      @(posedge clk);
      for (int unsigned i = 0; i < 3; i++) model_step(i, a[i]);
      #1;
      check_outputs(ph);
   endtask

   task automatic hold(input int n, input string ph);
      for (int k = 0; k < n; k++) cycle(3'b111, ph);
   endtask

   task automatic idle(input int n, input string ph);
      for (int k = 0; k < n; k++) cycle(3'b000, ph);
   endtask

   task automatic do_reset(input logic [2:0] a, input int n);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("rst_async");
      for (int k = 0; k < n; k++) begin
         btn = a ^ AL_MASK;
         @(posedge clk);
         #1;
         check_outputs("rst_hold");
      end
      rst_n = 1'b1;
   endtask

   initial begin
      btn = 3'b000 ^ AL_MASK;
      model_reset();
      #1;
      check_outputs("reset");
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");
      rst_n = 1'b1;

      idle(3, "pre");
      hold(3, "short3");       idle(4, "short3_rel");
      hold(22, "long22");      idle(4, "long22_rel");
      hold(L, "edge_rel");     idle(3, "edge_rel_rel");
      hold(L + 1, "just_long"); idle(3, "just_long_rel");
      hold(30, "hold30");      idle(3, "hold30_rel");
      hold(2, "short2");       idle(3, "short2_rel");

      hold(14, "mid_held");
      do_reset(3'b111, 2);
      hold(20, "held_thru_rst");
      idle(3, "after_rst_rel");
      hold(4, "post_rst");     idle(3, "post_rst_rel");

      for (int p = 0; p < 30; p++) begin
         hold($urandom_range(1, 25), "rnd_hold");
         idle($urandom_range(1, 6), "rnd_gap");
      end

      for (int k = 0; k < 300; k++) begin
         if (k == 150) do_reset(3'($urandom), 1);
         cycle(3'($urandom), "rnd_bits");
      end
      idle(3, "tail");

      check("cmd_count_inst0", 32'(dut_cmd_cnt), 32'(model_cmd_cnt));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
